// File: rtl/lsu_axi_slv_if.sv
// LSU <-> AXI responder bus: AW/W/B write channels, AR/R read channels and the oram tag side-band.
// The LSU drives the master modport; lsu_axi_slv sits on the slave modport.
interface lsu_axi_slv_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic [7:0]          lsu_axi_awid;
  logic [ADDR_W-1:0]   lsu_axi_awaddr;
  logic [7:0]          lsu_axi_awlen;
  logic [2:0]          lsu_axi_awsize;
  logic [1:0]          lsu_axi_awburst;
  logic [2:0]          lsu_axi_awstr;
  logic                lsu_axi_awvld;
  logic [11:0]         lsu_axi_oram_addr;
  logic [DATA_W-1:0]   lsu_axi_wdata;
  logic [DATA_W/8-1:0] lsu_axi_wstrb;
  logic                lsu_axi_wlast;
  logic                lsu_axi_wvld;
  logic                lsu_axi_brdy;
  logic                axi_lsu_awrdy;
  logic                axi_lsu_wrdy;
  logic                axi_lsu_bid;
  logic [1:0]          axi_lsu_bresp;
  logic                axi_lsu_bvld;
  logic [11:0]         axi_lsu_resp_oram_addr;

  logic [7:0]          lsu_axi_arid;
  logic [ADDR_W-1:0]   lsu_axi_araddr;
  logic [7:0]          lsu_axi_arlen;
  logic [2:0]          lsu_axi_arsize;
  logic [1:0]          lsu_axi_arburst;
  logic [2:0]          lsu_axi_arstr;
  logic                lsu_axi_arvld;
  logic                lsu_axi_rrdy;
  logic                axi_lsu_arrdy;
  logic [7:0]          axi_lsu_rid;
  logic [DATA_W-1:0]   axi_lsu_rdata;
  logic [1:0]          axi_lsu_rresp;
  logic                axi_lsu_rlast;
  logic                axi_lsu_rvld;

  modport master (
    output lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awburst,
           lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr, lsu_axi_wdata, lsu_axi_wstrb,
           lsu_axi_wlast, lsu_axi_wvld, lsu_axi_brdy,
           lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arvld, lsu_axi_rrdy,
    input  axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld,
           axi_lsu_resp_oram_addr, axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );

  modport slave (
    input  lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize, lsu_axi_awburst,
           lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr, lsu_axi_wdata, lsu_axi_wstrb,
           lsu_axi_wlast, lsu_axi_wvld, lsu_axi_brdy,
           lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arvld, lsu_axi_rrdy,
    output axi_lsu_awrdy, axi_lsu_wrdy, axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld,
           axi_lsu_resp_oram_addr, axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
           axi_lsu_rlast, axi_lsu_rvld
  );
endinterface

// File: rtl/lsu_axi_slv.sv
// AXI responder for the LSU master port backed by a word-addressed flop memory.
// Define LSU_AXI_SLV_BP_EN to add LFSR-driven pseudo-random backpressure on W and R.
module lsu_axi_slv #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 1 << ADDR_W,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_axi_slv_if.slave  bus
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr, w_step;
  logic [7:0]        w_len, w_cnt;
  logic              w_cmd_err, w_last_err, w_id0;
  logic [11:0]       w_oram;
  logic              awrdy_q, wrdy_q, bvld_q, bid_q;
  logic [1:0]        bresp_q;
  logic [11:0]       boram_q;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr, r_step;
  logic [7:0]        r_len, r_cnt;
  logic              r_err;
  logic              arrdy_q, rvld_q;
  logic [7:0]        rid_q;

  logic              w_hold_nxt, r_hold_nxt;
  logic              beat_last_err, mem_we;
  logic              unused_awid;

`ifdef LSU_AXI_SLV_BP_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= lfsr_nxt;
  end

  // Holds are computed from the value the LFSR takes at this edge so the
  // registered wrdy/rvld line up with the LFSR state visible in that cycle.
  assign w_hold_nxt = lfsr_nxt[0];
  assign r_hold_nxt = lfsr_nxt[1];
`else
  assign w_hold_nxt = 1'b0;
  assign r_hold_nxt = 1'b0;
`endif

  assign unused_awid   = ^bus.lsu_axi_awid[7:1];
  assign beat_last_err = bus.lsu_axi_wlast != (w_cnt == w_len);
  assign mem_we        = (w_state == W_DATA) && bus.lsu_axi_wvld && wrdy_q && !w_cmd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      w_addr     <= '0;
      w_step     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_cmd_err  <= 1'b0;
      w_last_err <= 1'b0;
      w_id0      <= 1'b0;
      w_oram     <= '0;
      awrdy_q    <= 1'b0;
      wrdy_q     <= 1'b0;
      bvld_q     <= 1'b0;
      bid_q      <= 1'b0;
      bresp_q    <= 2'd0;
      boram_q    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awrdy_q <= 1'b1;
          if (bus.lsu_axi_awvld && awrdy_q) begin
            awrdy_q    <= 1'b0;
            wrdy_q     <= !w_hold_nxt;
            w_state    <= W_DATA;
            w_addr     <= bus.lsu_axi_awaddr;
            w_len      <= bus.lsu_axi_awlen;
            w_cnt      <= '0;
            w_step     <= (bus.lsu_axi_awburst == 2'd1) ? ADDR_W'(bus.lsu_axi_awstr) + ADDR_W'(1) : '0;
            w_cmd_err  <= (bus.lsu_axi_awsize != 3'd3) || (bus.lsu_axi_awburst > 2'd1);
            w_last_err <= 1'b0;
            w_id0      <= bus.lsu_axi_awid[0];
            w_oram     <= bus.lsu_axi_oram_addr;
          end
        end
        W_DATA: begin
          wrdy_q <= !w_hold_nxt;
          if (bus.lsu_axi_wvld && wrdy_q) begin
            w_addr <= w_addr + w_step;
            w_cnt  <= w_cnt + 8'd1;
            // The beat count closes the burst; a misplaced wlast only taints the response.
            if (w_cnt == w_len) begin
              wrdy_q  <= 1'b0;
              bvld_q  <= 1'b1;
              bid_q   <= w_id0;
              bresp_q <= (w_cmd_err || w_last_err || beat_last_err) ? 2'd2 : 2'd0;
              boram_q <= w_oram;
              w_state <= W_RESP;
            end else if (beat_last_err) begin
              w_last_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bus.lsu_axi_brdy) begin
            bvld_q  <= 1'b0;
            bid_q   <= 1'b0;
            bresp_q <= 2'd0;
            boram_q <= '0;
            awrdy_q <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.lsu_axi_wstrb[b]) mem[w_addr][b*8 +: 8] <= bus.lsu_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      arrdy_q <= 1'b0;
      rvld_q  <= 1'b0;
      rid_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arrdy_q <= 1'b1;
          if (bus.lsu_axi_arvld && arrdy_q) begin
            arrdy_q <= 1'b0;
            rvld_q  <= !r_hold_nxt;
            r_state <= R_DATA;
            r_addr  <= bus.lsu_axi_araddr;
            r_len   <= bus.lsu_axi_arlen;
            r_cnt   <= '0;
            r_step  <= (bus.lsu_axi_arburst == 2'd1) ? ADDR_W'(bus.lsu_axi_arstr) + ADDR_W'(1) : '0;
            r_err   <= (bus.lsu_axi_arsize != 3'd3) || (bus.lsu_axi_arburst > 2'd1);
            rid_q   <= bus.lsu_axi_arid;
          end
        end
        R_DATA: begin
          if (rvld_q && bus.lsu_axi_rrdy) begin
            if (r_cnt == r_len) begin
              rvld_q  <= 1'b0;
              arrdy_q <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_addr <= r_addr + r_step;
              rvld_q <= !r_hold_nxt;
            end
          end else if (!rvld_q) begin
            rvld_q <= !r_hold_nxt;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.axi_lsu_awrdy          = awrdy_q;
  assign bus.axi_lsu_wrdy           = wrdy_q;
  assign bus.axi_lsu_bvld           = bvld_q;
  assign bus.axi_lsu_bid            = bid_q;
  assign bus.axi_lsu_bresp          = bresp_q;
  assign bus.axi_lsu_resp_oram_addr = boram_q;

  // Read data comes straight off the flop array, so a same-cycle write is seen one cycle later.
  assign bus.axi_lsu_arrdy = arrdy_q;
  assign bus.axi_lsu_rvld  = rvld_q;
  assign bus.axi_lsu_rid   = rid_q;
  assign bus.axi_lsu_rdata = (rvld_q && !r_err) ? mem[r_addr] : '0;
  assign bus.axi_lsu_rresp = (rvld_q && r_err) ? 2'd2 : 2'd0;
  assign bus.axi_lsu_rlast = rvld_q && (r_cnt == r_len);
endmodule

// File: tb/tb_lsu_axi_slv.sv
// Randomized self-checking bench for lsu_axi_slv against a flat-array memory model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lsu_axi_slv;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_axi_slv_if bus ();

  lsu_axi_slv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] model [1024];
  logic [63:0] wr_data [$];
  logic [7:0]  wr_strb [$];
  logic [63:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  logic [7:0]  rd_id   [$];

  // Memory model: each beat lands on (start + beat*stride) mod 1024, stride 0 for FIXED.
  function automatic logic [1:0] model_write(int addr, int len, int size, int burst, int str, int last_beat);
    bit err = (size != 3) || (burst > 1);
    int step = (burst == 1) ? str + 1 : 0;
    for (int i = 0; i <= len; i++)
      if (!err)
        for (int b = 0; b < 8; b++)
          if (wr_strb[i][b]) model[(addr + i * step) % 1024][b*8 +: 8] = wr_data[i][b*8 +: 8];
    return (err || last_beat != len) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [63:0] exp_data(int addr, int burst, int str, int i);
    int step = (burst == 1) ? str + 1 : 0;
    return model[(addr + i * step) % 1024];
  endfunction

  task automatic send_aw(int id, int addr, int len, int size, int burst, int str, int oram);
    int n = 0;
    @(negedge clk);
    bus.lsu_axi_awid      = 8'(id);
    bus.lsu_axi_awaddr    = 10'(addr);
    bus.lsu_axi_awlen     = 8'(len);
    bus.lsu_axi_awsize    = 3'(size);
    bus.lsu_axi_awburst   = 2'(burst);
    bus.lsu_axi_awstr     = 3'(str);
    bus.lsu_axi_oram_addr = 12'(oram);
    bus.lsu_axi_awvld     = 1'b1;
    while (!bus.axi_lsu_awrdy && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL aw_timeout awrdy=0 required=1"); end
    @(negedge clk);
    bus.lsu_axi_awvld = 1'b0;
  endtask

  task automatic send_w(logic [63:0] data, logic [7:0] strb, logic last);
    int n = 0;
    bus.lsu_axi_wdata = data;
    bus.lsu_axi_wstrb = strb;
    bus.lsu_axi_wlast = last;
    bus.lsu_axi_wvld  = 1'b1;
    while (!bus.axi_lsu_wrdy && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL w_timeout wrdy=0 required=1"); end
    @(negedge clk);
    bus.lsu_axi_wvld = 1'b0;
    bus.lsu_axi_wlast = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp, output logic bid, output logic [11:0] oram);
    int n = 0;
    while (!bus.axi_lsu_bvld && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL b_timeout bvld=0 required=1"); end
    resp = bus.axi_lsu_bresp;
    bid  = bus.axi_lsu_bid;
    oram = bus.axi_lsu_resp_oram_addr;
    bus.lsu_axi_brdy = 1'b1;
    @(negedge clk);
    bus.lsu_axi_brdy = 1'b0;
  endtask

  task automatic do_write(int id, int addr, int len, int size, int burst, int str, int oram, int last_beat,
                          output logic [1:0] resp, output logic bid, output logic [11:0] boram);
    send_aw(id, addr, len, size, burst, str, oram);
    for (int i = 0; i <= len; i++) send_w(wr_data[i], wr_strb[i], i == last_beat);
    get_b(resp, bid, boram);
  endtask

  task automatic send_ar(int id, int addr, int len, int size, int burst, int str);
    int n = 0;
    @(negedge clk);
    bus.lsu_axi_arid    = 8'(id);
    bus.lsu_axi_araddr  = 10'(addr);
    bus.lsu_axi_arlen   = 8'(len);
    bus.lsu_axi_arsize  = 3'(size);
    bus.lsu_axi_arburst = 2'(burst);
    bus.lsu_axi_arstr   = 3'(str);
    bus.lsu_axi_arvld   = 1'b1;
    while (!bus.axi_lsu_arrdy && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL ar_timeout arrdy=0 required=1"); end
    @(negedge clk);
    bus.lsu_axi_arvld = 1'b0;
  endtask

  task automatic collect_r(int beats);
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      while (!bus.axi_lsu_rvld && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) begin
        checks++; errors++;
        $display("FAIL r_timeout beat %0d rvld=0 required=1", i);
        break;
      end
      rd_data.push_back(bus.axi_lsu_rdata);
      rd_resp.push_back(bus.axi_lsu_rresp);
      rd_last.push_back(bus.axi_lsu_rlast);
      rd_id.push_back(bus.axi_lsu_rid);
      bus.lsu_axi_rrdy = 1'b1;
      @(negedge clk);
    end
    bus.lsu_axi_rrdy = 1'b0;
  endtask

  task automatic do_read(int id, int addr, int len, int size, int burst, int str);
    send_ar(id, addr, len, size, burst, str);
    collect_r(len + 1);
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    bus.lsu_axi_awvld = 1'b1; bus.lsu_axi_arvld = 1'b1; bus.lsu_axi_wvld = 1'b1;
    bus.lsu_axi_awaddr = 10'h55; bus.lsu_axi_araddr = 10'h66; bus.lsu_axi_awlen = 8'd3;
    repeat (3) @(negedge clk);
    outs = {bus.axi_lsu_awrdy, bus.axi_lsu_wrdy, bus.axi_lsu_bid, bus.axi_lsu_bresp, bus.axi_lsu_bvld,
            bus.axi_lsu_resp_oram_addr, bus.axi_lsu_arrdy, bus.axi_lsu_rid, bus.axi_lsu_rdata,
            bus.axi_lsu_rresp, bus.axi_lsu_rlast, bus.axi_lsu_rvld};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h required=0", outs); end
    bus.lsu_axi_awvld = 1'b0; bus.lsu_axi_arvld = 1'b0; bus.lsu_axi_wvld = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.axi_lsu_awrdy, bus.axi_lsu_arrdy} !== 2'b00) begin
      errors++; $display("FAIL ready_before_edge got=%b required=00", {bus.axi_lsu_awrdy, bus.axi_lsu_arrdy});
    end
    @(negedge clk);
    checks++;
    if ({bus.axi_lsu_awrdy, bus.axi_lsu_arrdy} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release got=%b required=11", {bus.axi_lsu_awrdy, bus.axi_lsu_arrdy});
    end
  endtask

  // Four 256-beat bursts give every word a known value; then a 256-beat read covers arlen=255.
  task automatic test_fill_long_burst();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    for (int blk = 0; blk < 4; blk++) begin
      wr_data.delete(); wr_strb.delete();
      for (int i = 0; i < 256; i++) begin
        wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF);
      end
      void'(model_write(blk * 256, 255, 3, 1, 0, 255));
      do_write(blk, blk * 256, 255, 3, 1, 0, 12'h0A0 + blk, 255, resp, bid, boram);
      checks++;
      if (resp !== 2'd0 || boram !== 12'(12'h0A0 + blk)) begin
        errors++; $display("FAIL fill_b blk %0d resp=%0d oram=%h required resp=0 oram=%h", blk, resp, boram, 12'h0A0 + blk);
      end
    end
    do_read(8'h5A, 0, 255, 3, 1, 0);
    checks++;
    if (rd_data.size() !== 256) begin errors++; $display("FAIL long_read_beats got=%0d required=256", rd_data.size()); end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (rd_data[i] !== model[i] || rd_last[i] !== (i == 255) || rd_resp[i] !== 2'd0 || rd_id[i] !== 8'h5A) begin
        errors++;
        $display("FAIL long_read beat %0d data=%h last=%b resp=%0d id=%h required data=%h last=%b resp=0 id=5a",
                 i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], model[i], i == 255);
      end
    end
  endtask

  task automatic test_incr_write_read();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i < 4; i++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    void'(model_write(10'h010, 3, 3, 1, 0, 3));
    do_write(8'h03, 10'h010, 3, 3, 1, 0, 12'h123, 3, resp, bid, boram);
    checks++;
    if (resp !== 2'd0 || bid !== 1'b1 || boram !== 12'h123) begin
      errors++; $display("FAIL incr_b resp=%0d bid=%b oram=%h required resp=0 bid=1 oram=123", resp, bid, boram);
    end
    do_read(8'h21, 10'h010, 3, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== wr_data[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'd0 || rd_id[i] !== 8'h21) begin
        errors++;
        $display("FAIL incr_read beat %0d data=%h last=%b resp=%0d id=%h required data=%h last=%b resp=0 id=21",
                 i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], wr_data[i], i == 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i < 2; i++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    void'(model_write(10'h3FE, 1, 3, 1, 1, 1));
    do_write(8'h00, 10'h3FE, 1, 3, 1, 1, 12'h7FF, 1, resp, bid, boram);
    checks++;
    if (resp !== 2'd0 || bid !== 1'b0) begin errors++; $display("FAIL wrap_b resp=%0d bid=%b required resp=0 bid=0", resp, bid); end
    do_read(8'h01, 10'h000, 0, 3, 1, 0);
    checks++;
    if (rd_data[0] !== wr_data[1]) begin errors++; $display("FAIL wrap_word0 got=%h required=%h", rd_data[0], wr_data[1]); end
    do_read(8'h02, 10'h3FE, 0, 3, 0, 0);
    checks++;
    if (rd_data[0] !== wr_data[0]) begin errors++; $display("FAIL wrap_word3fe got=%h required=%h", rd_data[0], wr_data[0]); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    wr_data = '{64'h1111_1111_1111_1111}; wr_strb = '{8'hFF};
    void'(model_write(5, 0, 3, 1, 0, 0));
    do_write(8'h10, 5, 0, 3, 1, 0, 12'h005, 0, resp, bid, boram);
    wr_data = '{64'hAAAA_AAAA_AAAA_AAAA}; wr_strb = '{8'h0F};
    void'(model_write(5, 0, 3, 1, 0, 0));
    do_write(8'h11, 5, 0, 3, 1, 0, 12'h006, 0, resp, bid, boram);
    checks++;
    if (resp !== 2'd0 || bid !== 1'b1 || boram !== 12'h006) begin
      errors++; $display("FAIL strobe_b resp=%0d bid=%b oram=%h required resp=0 bid=1 oram=006", resp, bid, boram);
    end
    do_read(8'h12, 5, 0, 3, 0, 0);
    checks++;
    if (rd_data[0] !== 64'h1111_1111_AAAA_AAAA || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL partial_strobe got=%h last=%b required=11111111aaaaaaaa last=1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i < 2; i++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    checks++;
    if (model_write(10'h020, 1, 2, 1, 0, 1) !== 2'd2) begin errors++; $display("FAIL model_size_err required=2"); end
    do_write(8'h33, 10'h020, 1, 2, 1, 0, 12'h220, 1, resp, bid, boram);
    checks++;
    if (resp !== 2'd2 || boram !== 12'h220) begin errors++; $display("FAIL size_err_b resp=%0d oram=%h required resp=2 oram=220", resp, boram); end
    do_read(8'h34, 10'h020, 1, 3, 1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== exp_data(10'h020, 1, 0, i)) begin
        errors++; $display("FAIL size_err_unchanged beat %0d got=%h required=%h", i, rd_data[i], exp_data(10'h020, 1, 0, i));
      end
    end
    do_read(8'h35, 10'h030, 3, 3, 2, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 64'd0 || rd_resp[i] !== 2'd2 || rd_last[i] !== (i == 3) || rd_id[i] !== 8'h35) begin
        errors++; $display("FAIL burst_err_read beat %0d data=%h resp=%0d last=%b required data=0 resp=2 last=%b",
                           i, rd_data[i], rd_resp[i], rd_last[i], i == 3);
      end
    end
  endtask

  task automatic test_wlast_mismatch();
    logic [1:0] resp; logic bid; logic [11:0] boram;
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i < 4; i++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    void'(model_write(10'h040, 3, 3, 1, 0, 2));
    do_write(8'h44, 10'h040, 3, 3, 1, 0, 12'h440, 2, resp, bid, boram);
    checks++;
    if (resp !== 2'd2 || bid !== 1'b0) begin errors++; $display("FAIL wlast_b resp=%0d bid=%b required resp=2 bid=0", resp, bid); end
    do_read(8'h45, 10'h040, 3, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== wr_data[i]) begin errors++; $display("FAIL wlast_written beat %0d got=%h required=%h", i, rd_data[i], wr_data[i]); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] d0; logic l0; int n = 0;
    send_ar(8'h66, 10'h010, 2, 3, 1, 0);
    while (!bus.axi_lsu_rvld && n < TMO) begin @(negedge clk); n++; end
    d0 = bus.axi_lsu_rdata; l0 = bus.axi_lsu_rlast;
    checks++;
    if (d0 !== model[10'h010] || l0 !== 1'b0) begin
      errors++; $display("FAIL stall_first data=%h last=%b required data=%h last=0", d0, l0, model[10'h010]);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.axi_lsu_rvld !== 1'b1 || bus.axi_lsu_rdata !== d0 || bus.axi_lsu_rlast !== l0) begin
        errors++; $display("FAIL stall_hold rvld=%b data=%h last=%b required rvld=1 data=%h last=%b",
                           bus.axi_lsu_rvld, bus.axi_lsu_rdata, bus.axi_lsu_rlast, d0, l0);
      end
    end
    collect_r(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data[i] !== model[10'h010 + i] || rd_last[i] !== (i == 2)) begin
        errors++; $display("FAIL stall_beats beat %0d data=%h last=%b required data=%h last=%b",
                           i, rd_data[i], rd_last[i], model[10'h010 + i], i == 2);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic seen_resp = 1'b0;
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i < 4; i++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    send_aw(8'h77, 10'h100, 3, 3, 1, 0, 12'h100);
    send_w(wr_data[0], 8'hFF, 1'b0);
    send_w(wr_data[1], 8'hFF, 1'b0);
    model[10'h100] = wr_data[0];
    model[10'h101] = wr_data[1];
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.axi_lsu_awrdy, bus.axi_lsu_wrdy, bus.axi_lsu_bvld, bus.axi_lsu_arrdy, bus.axi_lsu_rvld} !== 5'b0) begin
      errors++; $display("FAIL midburst_reset_outputs got=%b required=00000",
                         {bus.axi_lsu_awrdy, bus.axi_lsu_wrdy, bus.axi_lsu_bvld, bus.axi_lsu_arrdy, bus.axi_lsu_rvld});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); seen_resp |= bus.axi_lsu_bvld | bus.axi_lsu_rvld; end
    checks++;
    if (seen_resp !== 1'b0) begin errors++; $display("FAIL aborted_burst_response got=1 required=0"); end
    do_read(8'h78, 10'h100, 3, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== model[10'h100 + i]) begin
        errors++; $display("FAIL midburst_mem beat %0d got=%h required=%h", i, rd_data[i], model[10'h100 + i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic bid; logic [11:0] boram;
    for (int t = 0; t < 30; t++) begin
      int id = $urandom_range(0, 255);
      int addr = $urandom_range(0, 1023);
      int len = $urandom_range(0, 7);
      int burst = $urandom_range(0, 1);
      int str = $urandom_range(0, 7);
      int oram = $urandom_range(0, 4095);
      int last_beat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : len;
      int rid = $urandom_range(0, 255);
      wr_data.delete(); wr_strb.delete();
      for (int i = 0; i <= len; i++) begin
        wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'($urandom));
      end
      eresp = model_write(addr, len, 3, burst, str, last_beat);
      do_write(id, addr, len, 3, burst, str, oram, last_beat, resp, bid, boram);
      checks++;
      if (resp !== eresp || bid !== 1'(id) || boram !== 12'(oram)) begin
        errors++; $display("FAIL rand_b t=%0d resp=%0d bid=%b oram=%h required resp=%0d bid=%b oram=%h",
                           t, resp, bid, boram, eresp, 1'(id), 12'(oram));
      end
      do_read(rid, addr, len, 3, burst, str);
      for (int i = 0; i <= len; i++) begin
        checks++;
        if (rd_data[i] !== exp_data(addr, burst, str, i) || rd_last[i] !== (i == len) || rd_id[i] !== 8'(rid)) begin
          errors++; $display("FAIL rand_read t=%0d beat %0d data=%h last=%b id=%h required data=%h last=%b id=%h",
                             t, i, rd_data[i], rd_last[i], rd_id[i], exp_data(addr, burst, str, i), i == len, 8'(rid));
        end
      end
    end
  endtask

  initial begin
    bus.lsu_axi_awid = '0; bus.lsu_axi_awaddr = '0; bus.lsu_axi_awlen = '0; bus.lsu_axi_awsize = 3'd3;
    bus.lsu_axi_awburst = 2'd1; bus.lsu_axi_awstr = '0; bus.lsu_axi_awvld = 1'b0; bus.lsu_axi_oram_addr = '0;
    bus.lsu_axi_wdata = '0; bus.lsu_axi_wstrb = '0; bus.lsu_axi_wlast = 1'b0; bus.lsu_axi_wvld = 1'b0;
    bus.lsu_axi_brdy = 1'b0;
    bus.lsu_axi_arid = '0; bus.lsu_axi_araddr = '0; bus.lsu_axi_arlen = '0; bus.lsu_axi_arsize = 3'd3;
    bus.lsu_axi_arburst = 2'd1; bus.lsu_axi_arstr = '0; bus.lsu_axi_arvld = 1'b0; bus.lsu_axi_rrdy = 1'b0;

    test_reset();
    test_fill_long_burst();
    test_incr_write_read();
    test_wrap();
    test_partial_strobe();
    test_errors();
    test_wlast_mismatch();
    test_stall();
    test_reset_mid_burst();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
